// File: rtl/mac_weight_load_ctrl_pkg.sv
// rtl/mac_weight_load_ctrl_pkg.sv - shared state encoding and pipeline constants for the weight load controller
package mac_weight_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WAIT_SWAP,
        ST_SWAP,
        ST_DONE
    } state_t;

    // Cycles from a buffer read strobe to the matching prepare_weight
    localparam int RD_TO_PREP_LAT = 2;
    // Cycles between the last read and the swap wait, covering the tail of the load chain
    localparam int DRAIN_LEN = 2;

endpackage

// File: rtl/mac_weight_fetch_pipe.sv
// rtl/mac_weight_fetch_pipe.sv - delays buffer read strobe and captures read data into the column load chain head
module mac_weight_fetch_pipe
    import mac_weight_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        prepare_weight,
    output logic [7:0]  weight_0,
    output logic [7:0]  weight_1
);

    // The buffer contributes one cycle; data is captured when the delayed strobe meets it
    logic [RD_TO_PREP_LAT-2:0] en_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sr          <= '0;
            prepare_weight <= 1'b0;
            weight_0       <= '0;
            weight_1       <= '0;
        end else begin
            en_sr          <= {en_sr[RD_TO_PREP_LAT-2:0], rd_en} >> 0;
            prepare_weight <= en_sr[RD_TO_PREP_LAT-2];
            if (en_sr[RD_TO_PREP_LAT-2]) begin
                weight_0 <= rd_data[7:0];
                weight_1 <= rd_data[15:8];
            end
        end
    end

endmodule

// File: rtl/mac_weight_load_ctrl.sv
// rtl/mac_weight_load_ctrl.sv - weight tile fetch/shift/commit sequencer for one MAC column; MAC_WEIGHT_CTRL_STATS_EN adds o_stall_cycles
module mac_weight_load_ctrl
    import mac_weight_load_ctrl_pkg::*;
#(
    parameter int ARRAY_ROWS        = 8,
    parameter int BUFFER_ADDR_WIDTH = 15,
    parameter int TILE_CNT_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic [BUFFER_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [TILE_CNT_WIDTH-1:0]    i_tile_count,
    input  logic                         i_compute_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [TILE_CNT_WIDTH-1:0]    o_tile_idx,
    output logic                         o_buf_rd_en,
    output logic [BUFFER_ADDR_WIDTH-1:0] o_buf_addr,
    input  logic [15:0]                  i_buf_rd_data,
    output logic [7:0]                   o_load_weight_data_0,
    output logic [7:0]                   o_load_weight_data_1,
    output logic                         o_prepare_weight,
    output logic                         o_set_weight
`ifdef MAC_WEIGHT_CTRL_STATS_EN
    ,
    output logic [31:0]                  o_stall_cycles
`endif
);

    localparam int ROW_W = $clog2(ARRAY_ROWS + 1);
    localparam logic [ROW_W-1:0]             ROW_LAST   = ROW_W'(ARRAY_ROWS - 1);
    localparam logic [ROW_W-1:0]             ROW_ONE    = ROW_W'(1);
    localparam logic [1:0]                   DRAIN_LAST = 2'(DRAIN_LEN - 1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] ADDR_ONE   = BUFFER_ADDR_WIDTH'(1);
    localparam logic [TILE_CNT_WIDTH-1:0]    TILE_ONE   = TILE_CNT_WIDTH'(1);

    state_t                      state;
    logic [TILE_CNT_WIDTH-1:0]   tile_count;
    logic [TILE_CNT_WIDTH-1:0]   tile_next;
    logic [ROW_W-1:0]            row_cnt;
    logic [1:0]                  drain_cnt;

    assign tile_next = o_tile_idx + TILE_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tile_count   <= '0;
            row_cnt      <= '0;
            drain_cnt    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_tile_idx   <= '0;
            o_buf_rd_en  <= 1'b0;
            o_buf_addr   <= '0;
            o_set_weight <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_busy     <= 1'b1;
                        o_tile_idx <= '0;
                        o_buf_addr <= i_base_addr;
                        tile_count <= i_tile_count;
                        row_cnt    <= '0;
                        if (i_tile_count == '0) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= ST_FETCH;
                            o_buf_rd_en <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // Address keeps running so the next tile starts right after this one
                    o_buf_addr <= o_buf_addr + ADDR_ONE;
                    if (row_cnt == ROW_LAST) begin
                        o_buf_rd_en <= 1'b0;
                        drain_cnt   <= '0;
                        state       <= ST_DRAIN;
                    end else begin
                        row_cnt <= row_cnt + ROW_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= ST_WAIT_SWAP;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (i_compute_ready) begin
                        state        <= ST_SWAP;
                        o_set_weight <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    o_set_weight <= 1'b0;
                    o_tile_idx   <= tile_next;
                    row_cnt      <= '0;
                    if (tile_next == tile_count) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                    end else begin
                        state       <= ST_FETCH;
                        o_buf_rd_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MAC_WEIGHT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stall_cycles <= '0;
        end else if (state == ST_IDLE && i_start) begin
            o_stall_cycles <= '0;
        end else if (state == ST_WAIT_SWAP && !i_compute_ready && o_stall_cycles != '1) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

    mac_weight_fetch_pipe u_fetch_pipe (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_en          (o_buf_rd_en),
        .rd_data        (i_buf_rd_data),
        .prepare_weight (o_prepare_weight),
        .weight_0       (o_load_weight_data_0),
        .weight_1       (o_load_weight_data_1)
    );

endmodule

// File: tb/tb_mac_weight_load_ctrl.sv
// tb/tb_mac_weight_load_ctrl.sv - randomized and directed bench for mac_weight_load_ctrl against an event-time model
module tb_mac_weight_load_ctrl;

    localparam int R  = 4;
    localparam int AW = 15;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [TW-1:0] i_tile_count = '0;
    logic          i_compute_ready = 1'b1;
    logic [15:0]   i_buf_rd_data = '0;
    logic          o_busy, o_done, o_buf_rd_en, o_prepare_weight, o_set_weight;
    logic [TW-1:0] o_tile_idx;
    logic [AW-1:0] o_buf_addr;
    logic [7:0]    o_load_weight_data_0, o_load_weight_data_1;
`ifdef MAC_WEIGHT_CTRL_STATS_EN
    logic [31:0]   o_stall_cycles;
`endif

    mac_weight_load_ctrl #(
        .ARRAY_ROWS        (R),
        .BUFFER_ADDR_WIDTH (AW),
        .TILE_CNT_WIDTH    (TW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_start              (i_start),
        .i_base_addr          (i_base_addr),
        .i_tile_count         (i_tile_count),
        .i_compute_ready      (i_compute_ready),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_tile_idx           (o_tile_idx),
        .o_buf_rd_en          (o_buf_rd_en),
        .o_buf_addr           (o_buf_addr),
        .i_buf_rd_data        (i_buf_rd_data),
        .o_load_weight_data_0 (o_load_weight_data_0),
        .o_load_weight_data_1 (o_load_weight_data_1),
        .o_prepare_weight     (o_prepare_weight),
        .o_set_weight         (o_set_weight)
`ifdef MAC_WEIGHT_CTRL_STATS_EN
        ,
        .o_stall_cycles       (o_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight buffer: one cycle read latency, data pattern {addr+0x80, addr}
    always @(posedge clk) begin
        if (o_buf_rd_en) i_buf_rd_data <= {o_buf_addr[7:0] + 8'h80, o_buf_addr[7:0]};
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the job is described by event times (fetch start, set cycle, done cycle)
    int            m_fs = -1, m_set_at = -1, m_done_at = -1, m_busy_from = -1;
    int            m_tile = 0, m_count = 0;
    logic [AW-1:0] m_base = '0;
    bit            h_rd[2];
    logic [AW-1:0] h_addr[2];
    logic [7:0]    m_d0 = '0, m_d1 = '0;
    logic [31:0]   m_stall = '0;

    int rd_c_q[$], rd_a_q[$], prep_c_q[$], prep_d_q[$], set_q[$], done_q[$];

    always @(negedge clk) begin
        int            c;
        bit            e_rd, e_busy, e_prep;
        logic [AW-1:0] e_addr;
        c = cyc;
        if (!rst_n) begin
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_tile", o_tile_idx, 0);
            chk("rst_rd_en", o_buf_rd_en, 0);
            chk("rst_addr", o_buf_addr, 0);
            chk("rst_prep", o_prepare_weight, 0);
            chk("rst_set", o_set_weight, 0);
            chk("rst_w0", o_load_weight_data_0, 0);
            chk("rst_w1", o_load_weight_data_1, 0);
`ifdef MAC_WEIGHT_CTRL_STATS_EN
            chk("rst_stall", o_stall_cycles, 0);
`endif
            m_fs = -1; m_set_at = -1; m_done_at = -1; m_busy_from = -1;
            m_tile = 0; m_count = 0; m_d0 = '0; m_d1 = '0; m_stall = '0;
            h_rd[0] = 0; h_rd[1] = 0; h_addr[0] = '0; h_addr[1] = '0;
        end else begin
            e_rd   = (m_fs >= 0) && (c >= m_fs) && (c < m_fs + R);
            e_addr = m_base + AW'(m_tile * R + (c - m_fs));
            e_busy = (m_busy_from >= 0) && (c >= m_busy_from);
            e_prep = h_rd[1];
            if (e_prep) begin
                m_d0 = h_addr[1][7:0];
                m_d1 = h_addr[1][7:0] + 8'h80;
            end
            chk("rd_en", o_buf_rd_en, e_rd);
            if (e_rd) chk("rd_addr", o_buf_addr, e_addr);
            chk("busy", o_busy, e_busy);
            chk("done", o_done, c == m_done_at);
            chk("set_weight", o_set_weight, c == m_set_at);
            chk("tile_idx", o_tile_idx, m_tile);
            chk("prepare", o_prepare_weight, e_prep);
            chk("w0", o_load_weight_data_0, m_d0);
            chk("w1", o_load_weight_data_1, m_d1);
`ifdef MAC_WEIGHT_CTRL_STATS_EN
            chk("stall", o_stall_cycles, m_stall);
`endif
            if (o_buf_rd_en) begin rd_c_q.push_back(c); rd_a_q.push_back(int'(o_buf_addr)); end
            if (o_prepare_weight) begin
                prep_c_q.push_back(c);
                prep_d_q.push_back(int'({o_load_weight_data_1, o_load_weight_data_0}));
            end
            if (o_set_weight) set_q.push_back(c);
            if (o_done) done_q.push_back(c);

            h_rd[1] = h_rd[0]; h_rd[0] = e_rd;
            h_addr[1] = h_addr[0]; h_addr[0] = e_addr;
            if (c == m_set_at) begin
                m_set_at = -1;
                m_tile++;
                if (m_tile == m_count) begin m_fs = -1; m_done_at = c + 1; end
                else m_fs = c + 1;
            end
            if (c == m_done_at) begin
                m_busy_from = -1; m_done_at = -1;
            end else if (!e_busy && i_start) begin
                m_base = i_base_addr; m_count = int'(i_tile_count); m_tile = 0;
                m_stall = '0; m_busy_from = c + 1;
                if (m_count == 0) m_done_at = c + 1;
                else m_fs = c + 1;
            end
            if (m_fs >= 0 && m_set_at < 0 && c >= m_fs + R + 2) begin
                if (i_compute_ready) m_set_at = c + 1;
                else if (m_stall != '1) m_stall = m_stall + 32'd1;
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        rd_c_q.delete(); rd_a_q.delete(); prep_c_q.delete(); prep_d_q.delete();
        set_q.delete(); done_q.delete();
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [TW-1:0] cnt, output int t0);
        @(posedge clk); #1;
        clear_logs();
        i_base_addr = base; i_tile_count = cnt; i_start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic scenario_two_tiles(input string p);
        int t0;
        i_compute_ready = 1'b1;
        start_job(15'h0010, 8'd2, t0);
        wait_until(t0 + 18);
        @(negedge clk);
        chk({p, "_busy_c18"}, o_busy, 0);
        chk({p, "_nreads"}, rd_c_q.size(), 8);
        chk({p, "_rd0_cyc"}, rd_c_q[0] - t0, 1);
        chk({p, "_rd0_addr"}, rd_a_q[0], 32'h10);
        chk({p, "_rd4_cyc"}, rd_c_q[4] - t0, 9);
        chk({p, "_rd7_cyc"}, rd_c_q[7] - t0, 12);
        chk({p, "_rd7_addr"}, rd_a_q[7], 32'h17);
        chk({p, "_prep0_cyc"}, prep_c_q[0] - t0, 3);
        chk({p, "_prep0_data"}, prep_d_q[0], 32'h9010);
        chk({p, "_prep3_cyc"}, prep_c_q[3] - t0, 6);
        chk({p, "_prep3_data"}, prep_d_q[3], 32'h9313);
        chk({p, "_nsets"}, set_q.size(), 2);
        chk({p, "_set0_cyc"}, set_q[0] - t0, 8);
        chk({p, "_set1_cyc"}, set_q[1] - t0, 16);
        chk({p, "_done_cyc"}, done_q[0] - t0, 17);
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        scenario_two_tiles("s1");

        // Stalled swap plus an ignored start while busy
        i_compute_ready = 1'b0;
        start_job(15'h0100, 8'd1, t0);
        wait_until(t0 + 3);
        i_start = 1'b1; i_tile_count = 8'd5;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_until(t0 + 17);
        i_compute_ready = 1'b1;
        wait_until(t0 + 21);
        chk("stall_nreads", rd_c_q.size(), 4);
        chk("stall_nsets", set_q.size(), 1);
        chk("stall_set_cyc", set_q[0] - t0, 18);
        chk("stall_done_cyc", done_q[0] - t0, 19);
`ifdef MAC_WEIGHT_CTRL_STATS_EN
        chk("stall_count", o_stall_cycles, 10);
`endif

        // Address wrap
        start_job(15'h7FFE, 8'd1, t0);
        wait_until(t0 + 12);
        chk("wrap_a0", rd_a_q[0], 32'h7FFE);
        chk("wrap_a1", rd_a_q[1], 32'h7FFF);
        chk("wrap_a2", rd_a_q[2], 32'h0000);
        chk("wrap_a3", rd_a_q[3], 32'h0001);

        // Zero tiles; a start in the DONE cycle is ignored
        start_job(15'h0040, 8'd0, t0);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_until(t0 + 6);
        chk("zero_nreads", rd_c_q.size(), 0);
        chk("zero_nsets", set_q.size(), 0);
        chk("zero_ndone", done_q.size(), 1);
        chk("zero_done_cyc", done_q[0] - t0, 1);

        // Abort during FETCH of tile 0, then a clean rerun
        start_job(15'h0010, 8'd2, t0);
        wait_until(t0 + 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rd_en", o_buf_rd_en, 0);
        chk("abort_busy", o_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        scenario_two_tiles("s2");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            i_compute_ready = ($urandom_range(0, 3) != 0);
            i_start         = ($urandom_range(0, 9) == 0);
            i_base_addr     = AW'($urandom);
            i_tile_count    = TW'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0; i_start = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; i_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
